// File: rtl/aes_key_pkg.sv
// Shared definitions for the AES key loader: key-length codes, FSM encodings
// and the beat-count helper used to find the terminal count of a load.
package aes_key_pkg;

  localparam int AES_MAX_KEY_W = 256;

  localparam logic [1:0] KL_128 = 2'b00;
  localparam logic [1:0] KL_192 = 2'b01;
  localparam logic [1:0] KL_256 = 2'b10;
  localparam logic [1:0] KL_BAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Number of din beats that make up a key of the given length code.
  function automatic int key_beats(input logic [1:0] len_code, input int din_w);
    case (len_code)
      KL_128:  return 128 / din_w;
      KL_192:  return 192 / din_w;
      KL_256:  return AES_MAX_KEY_W / din_w;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/aes_key_shreg.sv
// Key assembly shift register: new beats enter at the LSB end so the first
// beat received ends up most significant once the load completes.
module aes_key_shreg #(
  parameter int KEY_W = 256,
  parameter int DIN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIN_W-1:0] din,
  output logic [KEY_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[KEY_W-DIN_W-1:0], din};
    end
  end

endmodule

// File: rtl/aes_key_loader.sv
// Serial key-load front end: collects a 128/192/256-bit key in DIN_W beats
// under valid/ready and flags completion with the active-low key_ok_.
//
// state | meaning
// IDLE  | no load in progress, waiting for cmd_sk
// LOAD  | accepting beats until the terminal count
// DONE  | key complete and held, key_ok_ low
module aes_key_loader
  import aes_key_pkg::*;
#(
  parameter int DIN_W = 8,
  parameter int KEY_W = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_sk,
  input  logic [1:0]       key_len,
  input  logic [DIN_W-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [KEY_W-1:0] key,
  output logic [1:0]       key_len_o,
  output logic             key_ok_,
  output logic             len_err
);

  localparam int CNT_W = $clog2(AES_MAX_KEY_W / DIN_W) + 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last_cnt;
  logic             accept;
  logic             sr_clr;

  // A restart command wins over a beat presented in the same cycle.
  assign accept   = din_valid & din_ready & ~cmd_sk;
  assign last_cnt = CNT_W'(key_beats(key_len_o, DIN_W) - 1);
  // An illegal code while idle leaves the key untouched; anywhere else it clears.
  assign sr_clr   = cmd_sk & ((key_len != KL_BAD) | (state != ST_IDLE));

  aes_key_shreg #(
    .KEY_W(KEY_W),
    .DIN_W(DIN_W)
  ) u_shreg (
    .clk(clk),
    .rst(rst),
    .clr(sr_clr),
    .en (accept),
    .din(din),
    .q  (key)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      key_len_o <= KL_128;
      din_ready <= 1'b0;
      key_ok_   <= 1'b1;
      len_err   <= 1'b0;
    end else begin
      len_err <= 1'b0;
      if (cmd_sk) begin
        cnt     <= '0;
        key_ok_ <= 1'b1;
        if (key_len == KL_BAD) begin
          len_err   <= 1'b1;
          state     <= ST_IDLE;
          din_ready <= 1'b0;
        end else begin
          state     <= ST_LOAD;
          key_len_o <= key_len;
          din_ready <= 1'b1;
        end
      end else if (accept) begin
        if (cnt == last_cnt) begin
          state     <= ST_DONE;
          din_ready <= 1'b0;
          key_ok_   <= 1'b0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_aes_key_loader.sv
// Directed bench for aes_key_loader: an 8-bit-beat instance exercises all
// key lengths, restart, illegal code and reset; a 32-bit-beat instance reruns the 128 load.
module tb_aes_key_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_sk;
  logic [1:0]   key_len;
  logic [7:0]   din;
  logic         din_valid;
  logic         din_ready;
  logic [255:0] key;
  logic [1:0]   key_len_o;
  logic         key_ok_;
  logic         len_err;

  logic         cmd32;
  logic [31:0]  din32;
  logic         valid32;
  logic         ready32;
  logic [255:0] key32;
  logic [1:0]   len_o32;
  logic         ok32_;
  logic         err32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_key_loader #(.DIN_W(8), .KEY_W(256)) dut8 (
    .clk(clk), .rst(rst), .cmd_sk(cmd_sk), .key_len(key_len), .din(din),
    .din_valid(din_valid), .din_ready(din_ready), .key(key),
    .key_len_o(key_len_o), .key_ok_(key_ok_), .len_err(len_err)
  );

  aes_key_loader #(.DIN_W(32), .KEY_W(256)) dut32 (
    .clk(clk), .rst(rst), .cmd_sk(cmd32), .key_len(key_len), .din(din32),
    .din_valid(valid32), .din_ready(ready32), .key(key32),
    .key_len_o(len_o32), .key_ok_(ok32_), .len_err(err32)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start8(input logic [1:0] len);
    cmd_sk  = 1'b1;
    key_len = len;
    step();
    cmd_sk  = 1'b0;
  endtask

  // Drives n beats (incrementing from first, or constant), optionally idling every 3rd cycle.
  task automatic send8(input int first, input int n, input bit gaps, input bit fixed);
    int sent = 0;
    int c = 0;
    while (sent < n && c < 200) begin
      if (gaps && (c % 3 == 2)) begin
        din_valid = 1'b0;
      end else begin
        din_valid = 1'b1;
        din       = fixed ? 8'(first) : 8'(first + sent);
        sent++;
      end
      step();
      c++;
    end
    din_valid = 1'b0;
    if (sent != n) chk("send_bound", 256'(sent), 256'(n));
  endtask

  initial begin
    rst = 1'b1; cmd_sk = 1'b0; key_len = 2'b00; din = '0; din_valid = 1'b0;
    cmd32 = 1'b0; din32 = '0; valid32 = 1'b0;
    step();
    step();
    chk("rst_key",     key, '0);
    chk("rst_len",     256'(key_len_o), 256'(2'b00));
    chk("rst_ready",   256'(din_ready), 256'(1'b0));
    chk("rst_ok",      256'(key_ok_), 256'(1'b1));
    chk("rst_err",     256'(len_err), 256'(1'b0));
    rst = 1'b0;
    step();

    // Illegal code while idle: pulse only, key stays zero
    cmd_sk = 1'b1; key_len = 2'b11;
    step();
    cmd_sk = 1'b0;
    chk("idle_bad_err",   256'(len_err), 256'(1'b1));
    chk("idle_bad_ready", 256'(din_ready), 256'(1'b0));
    step();
    chk("idle_bad_pulse", 256'(len_err), 256'(1'b0));

    // Case 1: 128-bit load, back-to-back
    start8(2'b00);
    chk("c1_ready", 256'(din_ready), 256'(1'b1));
    send8(0, 15, 1'b0, 1'b0);
    chk("c1_ok_early", 256'(key_ok_), 256'(1'b1));
    send8(15, 1, 1'b0, 1'b0);
    chk("c1_ok",    256'(key_ok_), 256'(1'b0));
    chk("c1_key",   key, 256'h000102030405060708090a0b0c0d0e0f);
    chk("c1_ready_done", 256'(din_ready), 256'(1'b0));

    // Case 2: 256-bit load with gaps
    start8(2'b10);
    chk("c2_ok_restart", 256'(key_ok_), 256'(1'b1));
    send8(0, 32, 1'b1, 1'b0);
    chk("c2_key", key, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    chk("c2_len", 256'(key_len_o), 256'(2'b10));
    chk("c2_ok",  256'(key_ok_), 256'(1'b0));

    // Case 3: 192-bit load, extra beats in DONE ignored
    start8(2'b01);
    send8(0, 24, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      din_valid = 1'b1;
      din       = 8'haa;
      step();
      chk("c3_ready_done", 256'(din_ready), 256'(1'b0));
    end
    din_valid = 1'b0;
    chk("c3_key", key, 256'h000102030405060708090a0b0c0d0e0f1011121314151617);
    chk("c3_len", 256'(key_len_o), 256'(2'b01));
    chk("c3_ok",  256'(key_ok_), 256'(1'b0));

    // Case 4: restart mid-load; the beat presented with cmd_sk is dropped
    start8(2'b00);
    send8(0, 7, 1'b0, 1'b0);
    cmd_sk = 1'b1; key_len = 2'b00; din_valid = 1'b1; din = 8'h55;
    step();
    cmd_sk = 1'b0; din_valid = 1'b0;
    chk("c4_key_clr", key, '0);
    chk("c4_ok_hi",   256'(key_ok_), 256'(1'b1));
    send8(8'hff, 15, 1'b0, 1'b1);
    chk("c4_ok_early", 256'(key_ok_), 256'(1'b1));
    send8(8'hff, 1, 1'b0, 1'b1);
    chk("c4_key", key, {128'd0, {128{1'b1}}});
    chk("c4_ok",  256'(key_ok_), 256'(1'b0));

    // Case 5: illegal code in DONE
    cmd_sk = 1'b1; key_len = 2'b11;
    step();
    cmd_sk = 1'b0; key_len = 2'b00;
    chk("c5_err",   256'(len_err), 256'(1'b1));
    chk("c5_key",   key, '0);
    chk("c5_ok",    256'(key_ok_), 256'(1'b1));
    chk("c5_ready", 256'(din_ready), 256'(1'b0));
    step();
    chk("c5_pulse", 256'(len_err), 256'(1'b0));
    din_valid = 1'b1; din = 8'h77;
    step();
    step();
    din_valid = 1'b0;
    chk("c5_idle_key", key, '0);

    // Case 6: reset mid-load, then a fresh 128 load
    start8(2'b10);
    send8(0, 10, 1'b0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("c6_rst_key",   key, '0);
    chk("c6_rst_ok",    256'(key_ok_), 256'(1'b1));
    chk("c6_rst_ready", 256'(din_ready), 256'(1'b0));
    chk("c6_rst_len",   256'(key_len_o), 256'(2'b00));
    start8(2'b00);
    send8(8'h10, 16, 1'b0, 1'b0);
    chk("c6_key", key, 256'h101112131415161718191a1b1c1d1e1f);
    chk("c6_ok",  256'(key_ok_), 256'(1'b0));

    // DIN_W=32 rerun of case 1: four beats
    cmd32 = 1'b1; key_len = 2'b00;
    step();
    cmd32 = 1'b0;
    chk("w32_ready", 256'(ready32), 256'(1'b1));
    valid32 = 1'b1;
    din32 = 32'h00010203; step();
    din32 = 32'h04050607; step();
    din32 = 32'h08090a0b; step();
    chk("w32_ok_early", 256'(ok32_), 256'(1'b1));
    din32 = 32'h0c0d0e0f; step();
    valid32 = 1'b0;
    chk("w32_ok",  256'(ok32_), 256'(1'b0));
    chk("w32_key", key32, 256'h000102030405060708090a0b0c0d0e0f);
    chk("w32_len", 256'(len_o32), 256'(2'b00));
    chk("w32_err", 256'(err32), 256'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
